// File: rtl/issue_sequencer.sv
// issue_sequencer: single-issue control FSM between fetch and the integer datapath.
// Holds the instruction register that feeds the decoder and sequences execute,
// LSU wait, PC redirect and halt from the decoder's control outputs.
// Optional feature: define ISSUE_LSU_TIMEOUT_EN to abandon an LSU access that
// has not completed after LSU_TIMEOUT wait cycles and halt the sequencer.
module issue_sequencer #(
  parameter int CNT_W       = 32,
  parameter int LSU_TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             FetchValid,
  output logic             FetchReady,
  input  logic [31:0]      FetchInstr,
  input  logic [31:0]      FetchPc,
  output logic             FetchFlush,
  output logic [31:0]      DecInstr,
  input  logic             DecValid,
  input  logic [3:0]       DecLsu,
  input  logic             DecMultiCycle,
  input  logic [1:0]       DecPcMode,
  input  logic             BrTaken,
  output logic [31:0]      ExecPc,
  output logic             ExecEn,
  output logic             LsuReq,
  input  logic             LsuAck,
  output logic             RedirectValid,
  output logic             IllegalInstr,
  output logic             LsuTimeout,
  output logic             Halted,
  input  logic             Resume,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MEM_WAIT,
    REDIRECT,
    HALT
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [31:0]      ir;
  logic [31:0]      execPc;
  logic [CNT_W-1:0] retireCount;

  logic lsuAccess;
  logic pcChange;
  logic loadIr;
  logic timeoutHit;
  logic lsuTimeoutPulse;

  // Memory ops and multi-cycle ops both go through the LSU handshake.
  assign lsuAccess = (DecLsu[1:0] != 2'b00) || DecMultiCycle;

  // Jumps always redirect; a branch only when the ALU says it is taken.
  assign pcChange = DecPcMode[1] || ((DecPcMode == 2'b01) && BrTaken);

  // A word is taken whenever the sequencer is ready and fetch offers one.
  assign loadIr = FetchReady && FetchValid;

  assign DecInstr    = ir;
  assign ExecPc      = execPc;
  assign RetireCount = retireCount;
  assign LsuTimeout  = lsuTimeoutPulse;

`ifdef ISSUE_LSU_TIMEOUT_EN
  localparam int CLOG_W = $clog2(LSU_TIMEOUT + 1);
  localparam int WAIT_W = (CLOG_W > 8) ? CLOG_W : 8;

  logic [WAIT_W-1:0] waitCnt;

  // Wait counter sits at zero outside MEM_WAIT so it starts clean on every entry.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      waitCnt <= '0;
    end else if (state != MEM_WAIT) begin
      waitCnt <= '0;
    end else if (!LsuAck && (waitCnt != WAIT_W'(LSU_TIMEOUT))) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  // An acknowledge arriving together with the limit still retires normally.
  assign timeoutHit = (state == MEM_WAIT) && !LsuAck &&
                      (waitCnt == WAIT_W'(LSU_TIMEOUT));
`else
  logic [31:0] unusedTimeoutLimit;

  assign unusedTimeoutLimit = 32'(LSU_TIMEOUT);
  assign timeoutHit         = 1'b0;
`endif

  // The sign and mode LSU bits belong to the datapath, not to sequencing.
  logic unusedLsuBits;
  assign unusedLsuBits = ^DecLsu[3:2];

  // State register; reset drops straight to IDLE so LsuReq falls without a clock.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    nextState       = state;
    FetchReady      = 1'b0;
    ExecEn          = 1'b0;
    LsuReq          = 1'b0;
    RedirectValid   = 1'b0;
    FetchFlush      = 1'b0;
    IllegalInstr    = 1'b0;
    Halted          = 1'b0;
    lsuTimeoutPulse = 1'b0;
    case (state)
      IDLE: begin
        FetchReady = 1'b1;
        if (FetchValid) begin
          nextState = EXEC;
        end
      end
      EXEC: begin
        if (!DecValid) begin
          IllegalInstr = 1'b1;
          nextState    = HALT;
        end else if (lsuAccess) begin
          LsuReq    = 1'b1;
          nextState = MEM_WAIT;
        end else if (pcChange) begin
          ExecEn    = 1'b1;
          nextState = REDIRECT;
        end else begin
          ExecEn     = 1'b1;
          FetchReady = 1'b1;
          nextState  = FetchValid ? EXEC : IDLE;
        end
      end
      MEM_WAIT: begin
        if (LsuAck) begin
          ExecEn    = 1'b1;
          nextState = IDLE;
        end else if (timeoutHit) begin
          lsuTimeoutPulse = 1'b1;
          nextState       = HALT;
        end else begin
          LsuReq = 1'b1;
        end
      end
      REDIRECT: begin
        RedirectValid = 1'b1;
        FetchFlush    = 1'b1;
        nextState     = IDLE;
      end
      HALT: begin
        Halted = 1'b1;
        if (Resume) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Instruction register and its PC load together on every accepted fetch.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ir     <= '0;
      execPc <= '0;
    end else if (loadIr) begin
      ir     <= FetchInstr;
      execPc <= FetchPc;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      retireCount <= '0;
    end else if (ExecEn) begin
      retireCount <= retireCount + CNT_W'(1);
    end
  end

endmodule
